// File: rtl/seq_mul16.sv
// seq_mul16: unsigned WIDTH x WIDTH -> 2*WIDTH shift-add multiplier, one partial sum per cycle.
// Latency: start accepted at edge k, done pulses for the cycle after edge k+WIDTH; busy high in between.
// Backpressure: none; start is taken only in IDLE or DONE and ignored while busy, product held until next done.
//
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   start, a, b      operation request with multiplicand a and multiplier b (captured on accept)
//   busy, done       busy while stepping; done is a single-cycle pulse when product updates
//   product          last completed result, stable between done pulses
module seq_mul16 #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH:0]     acc_hi_q;   // bit WIDTH holds the carry of the partial sum
    logic [WIDTH-1:0]   acc_lo_q;   // multiplier bits shift out as product bits shift in
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [2*WIDTH-1:0] product_q;

    logic [WIDTH:0]     sum_d;
    logic [2*WIDTH:0]   shift_d;
    logic [WIDTH:0]     acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_d;
    logic               last_step;

    // acc_hi_q[WIDTH] is always zero on entry to a step (it was shifted down
    // on the previous edge), so adding the full register equals adding its
    // low half; the 17-bit sum keeps the carry so the shift brings it down.
    always_comb begin
        sum_d = acc_hi_q;
        if (acc_lo_q[0]) begin
            sum_d = acc_hi_q + {1'b0, mcand_q};
        end
        shift_d  = {sum_d, acc_lo_q} >> 1;
        acc_hi_d = shift_d[2*WIDTH:WIDTH];
        acc_lo_d = shift_d[WIDTH-1:0];
    end

    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                // DONE accepts a new start exactly like IDLE, giving back-to-back issue.
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q  <= a;
                        acc_hi_q <= '0;
                        acc_lo_q <= b;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_step) begin
                        // Post-shift value: the full product sits in the low 2*WIDTH bits.
                        product_q <= shift_d[2*WIDTH-1:0];
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_mul16.sv
// tb_seq_mul16: directed and random checks of seq_mul16 against a plain multiply model.
// Latency: each operation is expected to finish 16 edges after its accept edge.
// Backpressure: the bench only issues start while busy is low.
module tb_seq_mul16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int          n_vec;
    int          n_err;
    int          cyc;
    logic [31:0] last_prod;
    logic [31:0] exp_q[$];
    int          acc_q[$];
    int          done_cyc_q[$];

    seq_mul16 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: every done must match the oldest outstanding operation, arrive
    // 16 edges after its accept edge, and product must not move otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            assert (busy || !$isunknown(start)) else $error("start unknown while not busy");
            if (done) begin
                chk("busy_at_done", 64'(busy), 64'(0));
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 64'(1), 64'(0));
                end else begin
                    logic [31:0] e;
                    int          k;
                    e = exp_q.pop_front();
                    k = acc_q.pop_front();
                    chk("product", 64'(product), 64'(e));
                    chk("latency", 64'(cyc - k), 64'(16));
                    last_prod = e;
                end
                done_cyc_q.push_back(cyc);
            end else begin
                chk("hold", 64'(product), 64'(last_prod));
            end
        end
    end

    // Called at a negedge with busy low; returns at the negedge of the DONE
    // cycle (gap 0, caller must issue next) or gap idle cycles later.
    task automatic issue(input logic [15:0] x, input logic [15:0] y, input int gap, input bit hold);
        bit ok;
        ok = 1'b0;
        a = x;
        b = y;
        start = 1'b1;
        exp_q.push_back(32'(x) * 32'(y));
        @(posedge clk);
        #1;
        acc_q.push_back(cyc);
        start = hold;
        a = 16'($urandom);
        b = 16'($urandom);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            start = hold ? 1'b1 : 1'($urandom);
            a = 16'($urandom);
            b = 16'($urandom);
        end
        chk("op_complete", 64'(ok), 64'(1));
        if (gap > 0) begin
            start = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        last_prod = '0;
        start = 1'b0;
        a = '0;
        b = '0;
        rst_n = 1'b0;
        #12;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_product", 64'(product), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed operands, including carry-heavy and zero cases.
        issue(16'd3, 16'd5, 2, 1'b0);
        issue(16'hFFFF, 16'hFFFF, 2, 1'b0);
        issue(16'h1234, 16'h0000, 1, 1'b0);
        issue(16'h0000, 16'hABCD, 1, 1'b0);
        issue(16'h8000, 16'h0002, 2, 1'b0);

        // Back-to-back with start held high through RUN.
        issue(16'd7, 16'd9, 0, 1'b1);
        issue(16'h0100, 16'h0100, 2, 1'b1);
        if (done_cyc_q.size() >= 2) begin
            chk("b2b_spacing", 64'(done_cyc_q[done_cyc_q.size()-1] - done_cyc_q[done_cyc_q.size()-2]), 64'(17));
        end else begin
            chk("b2b_done_count", 64'(done_cyc_q.size()), 64'(2));
        end

        // Asynchronous reset in the middle of RUN discards the operation.
        a = 16'h00FF;
        b = 16'h00FF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2;
        rst_n = 1'b0;
        last_prod = '0;
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        chk("midrst_product", 64'(product), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        issue(16'd2, 16'd3, 2, 1'b0);

        // Random regression with 0..3 idle cycles between operations.
        for (int n = 0; n < 1000; n++) begin
            int g;
            g = (n == 999) ? 1 : int'($urandom_range(0, 3));
            issue(16'($urandom), 16'($urandom), g, 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("drain", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_mul16.md
Name: seq_mul16

Overview:
- Multi-cycle unsigned 16x16 -> 32-bit shift-add multiplier for the datapath.
- Each cycle it forms one 16-bit partial sum, multiplicand plus accumulator high half, and shifts right one bit.
- Sits beside the 16-bit ripple adder in the execute stage and produces MUL results for writeback.
- Start/busy/done handshake with the sequencer; result is held until the next operation completes.

Parameters:
- WIDTH, 16, operand width; product is 2*WIDTH. Only 16 is verified.
- CNT_W, 5, step-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiply; sampled only when busy=0.
- a  input  16  multiplicand; captured on accepted start.
- b  input  16  multiplier; captured on accepted start.
- busy  output  1  high while a multiply is in progress.
- done  output  1  single-cycle pulse when product updates.
- product  output  32  last completed result; stable between done pulses.

Behaviour:
- Reset (rst_n=0, asynchronous, any state): state=IDLE, busy=0, done=0, product=0, internal accumulator and counter cleared.
- An in-flight operation is discarded on reset; no done is issued for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k: latch mcand=a, acc_hi=0 (17 bits incl. carry), acc_lo=b, cnt=0, go to RUN.
  - busy=1 from after edge k.
- RUN, one step per edge:
  - If acc_lo[0]=1: sum = acc_hi[15:0] + mcand as a 17-bit result; otherwise sum = {0, acc_hi[15:0]}.
  - {acc_hi, acc_lo} <= {sum, acc_lo} >> 1, a 33-bit logical shift.
  - cnt increments.
  - start is ignored; a and b may change freely.
- After the 16th RUN edge (edge k+16):
  - product <= {acc_hi[15:0], acc_lo}, the post-shift value.
  - state=DONE, done=1, busy=0.
- Latency: accepted start at edge k, then done high in the cycle after edge k+16 (16 cycles busy).
- DONE lasts exactly one cycle.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back: next RUN, done drops, busy rises).
  - Otherwise go to IDLE.
  - Sustained throughput is one result per 17 cycles.
- product register:
  - Written only on entry to DONE.
  - Holds its value through subsequent RUN phases, so a reader may sample it any time after done.
- Arithmetic:
  - Unsigned only; the full 32-bit result never overflows.
  - The carry out of each 16-bit sum is preserved in acc_hi[16] before the shift; it must not be dropped.
- Zero operands still take the full 16 cycles; there is no early termination.
- done and busy are never high together. busy=0 and done=0 in IDLE.
- X on start while in IDLE is a protocol violation; the bench asserts start is known whenever busy=0.

Test Plan:
- Reset, then a=3, b=5, start for 1 cycle -> busy high for 16 cycles, then done for 1 cycle with product=0x0000000F; busy=0 during done.
- a=0xFFFF, b=0xFFFF -> product=0xFFFE0001, which exercises carry into acc_hi[16] on every step. Also a=0x8000, b=0x0002 -> 0x00010000.
- a=0x1234, b=0 and a=0, b=0xABCD -> product=0 after the full 16-cycle latency. product holds the prior value (0xFFFE0001) until that done.
- Back-to-back: hold start=1 continuously with a=7, b=9, then a=0x0100, b=0x0100 presented in the DONE cycle.
  - Required: done pulses 17 cycles apart, products 0x3F then 0x00010000.
  - start pulses and changes to a/b during RUN are ignored.
- Reset mid-operation: assert rst_n=0 asynchronously at cycle 8 of RUN.
  - Required: busy, done and product go to 0 immediately, with no clock edge needed.
  - After release: no spurious done; a new start with a=2, b=3 gives 6.
- Random regression: 1000 random a/b pairs against a 32-bit reference multiply, with start gaps of 0-3 cycles between operations.
